// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the instruction fetch path
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  // Sequential instruction address; wraps modulo 2^32.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular prefetch queue of {instr, pc+4} entries
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  word_t      i_instr,
  input  word_t      i_pcinc,
  output logic       o_full,
  output logic       o_empty,
  output logic [4:0] o_count,
  output word_t      o_instr,
  output word_t      o_pcinc
);

  localparam int PW = $clog2(DEPTH);

  word_t          r_instr_mem [DEPTH];
  word_t          r_pcinc_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [4:0]     r_count;
  logic           w_do_pop;
  logic           w_do_push;

  assign o_full    = (r_count == 5'(DEPTH));
  assign o_empty   = (r_count == 5'd0);
  assign o_count   = r_count;
  // Flush wins over same-cycle traffic; pop on empty is dropped; a push into a
  // full queue only lands when a pop frees the slot in the same cycle.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
  // Head is forced to zero when empty so outputs are clean out of reset.
  assign o_instr   = o_empty ? '0 : r_instr_mem[r_rd_ptr];
  assign o_pcinc   = o_empty ? '0 : r_pcinc_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + 5'(w_do_push) - 5'(w_do_pop);
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_instr_mem[r_wr_ptr] <= i_instr;
      r_pcinc_mem[r_wr_ptr] <= i_pcinc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with prefetch queue and redirect squash
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0,
  parameter int    DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  word_t      imemload,
  output logic       imemREN,
  output word_t      imemaddr,
  input  logic       redirect,
  input  word_t      redirect_pc,
  input  logic       halt,
  input  logic       fq_pop,
  output logic       fq_valid,
  output word_t      fq_instr,
  output word_t      fq_pcinc,
  output logic [4:0] fq_count
);

  fetch_state_t r_state;
  word_t        r_pc;
  word_t        r_sq_addr;
  logic         w_push;
  logic         w_pop_eff;
  logic         w_full;
  logic         w_empty;
  logic [4:0]   w_count_next;

  // Only a live (non-squashed, non-redirected) completion enters the queue.
  assign w_push       = (r_state == FETCH) && ihit && !redirect;
  assign w_pop_eff    = fq_pop && !w_empty;
  assign w_count_next = fq_count + 5'(w_push) - 5'(w_pop_eff);

  assign imemREN  = (r_state != IDLE);
  assign imemaddr = (r_state == SQUASH) ? r_sq_addr : r_pc;
  assign fq_valid = !w_empty;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_push  (w_push),
    .i_pop   (fq_pop),
    .i_flush (redirect),
    .i_instr (imemload),
    .i_pcinc (pc_plus4(r_pc)),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fq_count),
    .o_instr (fq_instr),
    .o_pcinc (fq_pcinc)
  );

  // Request sequencing: PC advance, redirect capture and squash of stale requests.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_pc      <= PC_INIT;
      r_sq_addr <= '0;
    end else begin
      if (redirect) r_pc <= redirect_pc;
      case (r_state)
        IDLE: begin
          if (redirect)
            r_state <= halt ? IDLE : FETCH;
          else if (!halt && !w_full)
            r_state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            if (ihit) begin
              r_state <= halt ? IDLE : FETCH;
            end else begin
              // Memory still owes us the old word; hold its address until it lands.
              r_sq_addr <= r_pc;
              r_state   <= SQUASH;
            end
          end else if (ihit) begin
            r_pc    <= pc_plus4(r_pc);
            r_state <= (!halt && (w_count_next < 5'(DEPTH))) ? FETCH : IDLE;
          end
        end
        SQUASH: begin
          if (ihit) r_state <= halt ? IDLE : FETCH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
